// File: rtl/cpu_pkg.sv
// Shared CPU definitions: phase indices, default phase count and sequencer states.
package cpu_pkg;
  localparam int NUM_PHASES_DEF = 5;

  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_MEM    = 3;
  localparam int PH_WB     = 4;

  typedef enum logic {ST_RUN, ST_HALTED} seq_state_e;
endpackage

// File: rtl/phase_next_pick.sv
// Finds the lowest unmasked phase index strictly above k; wrap=1 when none exists.
module phase_next_pick
  import cpu_pkg::*;
#(
  parameter int NUM_PHASES = NUM_PHASES_DEF,
  localparam int IW = $clog2(NUM_PHASES)
) (
  input  logic [IW-1:0]         k,
  input  logic [NUM_PHASES-1:0] mask,
  output logic [IW-1:0]         nxt,
  output logic                  wrap
);
  // Scan from the top so the lowest qualifying index is written last.
  always_comb begin
    nxt  = '0;
    wrap = 1'b1;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (IW'(i) > k && !mask[i]) begin
        nxt  = IW'(i);
        wrap = 1'b0;
      end
    end
  end
endmodule

// File: rtl/phase_seq.sv
// One-hot instruction phase sequencer with skip, stall, boundary halt and resume.
// Define PHASE_SEQ_PERF_CNT_EN to build the cycle/instruction counters.
module phase_seq
  import cpu_pkg::*;
#(
  parameter int NUM_PHASES = NUM_PHASES_DEF,
  parameter int CNT_W      = 32,
  localparam int IW = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [NUM_PHASES-1:0] skip_mask,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [NUM_PHASES-1:0] phase,
  output logic [IW-1:0]         phase_idx,
  output logic                  instr_done,
  output logic                  halted,
  output logic [CNT_W-1:0]      cyc_cnt,
  output logic [CNT_W-1:0]      ins_cnt
);
  seq_state_e            state;
  logic [NUM_PHASES-1:0] mask_q;
  logic [NUM_PHASES-1:0] pick_mask;
  logic                  pend;
  logic [IW-1:0]         nxt;
  logic                  wrap;

  // In fetch the fresh skip_mask steers the pick in the same cycle it is latched.
  assign pick_mask = (phase_idx == '0) ? (skip_mask & ~NUM_PHASES'(1)) : mask_q;

  phase_next_pick #(.NUM_PHASES(NUM_PHASES)) u_pick (
    .k    (phase_idx),
    .mask (pick_mask),
    .nxt  (nxt),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      phase      <= NUM_PHASES'(1);
      phase_idx  <= '0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
      mask_q     <= '0;
      pend       <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      if (state == ST_RUN) begin
        if (stall) begin
          pend <= pend | halt_req;
        end else begin
          if (phase_idx == '0) mask_q <= pick_mask;
          if (wrap) begin
            instr_done <= 1'b1;
            phase_idx  <= '0;
            if (pend | halt_req) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
              phase  <= '0;
              pend   <= 1'b0;
            end else begin
              phase <= NUM_PHASES'(1);
            end
          end else begin
            phase     <= NUM_PHASES'(1) << nxt;
            phase_idx <= nxt;
            pend      <= pend | halt_req;
          end
        end
      end else if (resume) begin
        // A simultaneous halt_req arms a halt after exactly one more instruction.
        state     <= ST_RUN;
        halted    <= 1'b0;
        phase     <= NUM_PHASES'(1);
        phase_idx <= '0;
        pend      <= halt_req;
      end
    end
  end

`ifdef PHASE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else if (state == ST_RUN) begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (!stall && wrap) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`else
  assign cyc_cnt = '0;
  assign ins_cnt = '0;
`endif
endmodule

// File: tb/tb_phase_seq.sv
// Self-checking bench for phase_seq: directed vector table, hand sequences, random vs model.
module tb_phase_seq;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic [N-1:0] skip_mask;
  logic         halt_req;
  logic         resume;
  logic [N-1:0] phase;
  logic [2:0]   phase_idx;
  logic         instr_done;
  logic         halted;
  logic [31:0]  cyc_cnt;
  logic [31:0]  ins_cnt;

  int checks = 0;
  int errors = 0;

  phase_seq #(.NUM_PHASES(N), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .skip_mask  (skip_mask),
    .halt_req   (halt_req),
    .resume     (resume),
    .phase      (phase),
    .phase_idx  (phase_idx),
    .instr_done (instr_done),
    .halted     (halted),
    .cyc_cnt    (cyc_cnt),
    .ins_cnt    (ins_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         stall;
    logic [N-1:0] skip;
    logic         halt;
    logic         res;
    logic [N-1:0] exp_phase;
    logic         exp_done;
    logic         exp_halted;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic t(input logic s, input logic [N-1:0] sk, input logic h, input logic r,
                   input logic [N-1:0] ph, input logic d, input logic hl);
    vec_t v;
    v.stall = s; v.skip = sk; v.halt = h; v.res = r;
    v.exp_phase = ph; v.exp_done = d; v.exp_halted = hl;
    tv.push_back(v);
  endtask

  task automatic drive(input logic s, input logic [N-1:0] sk, input logic h, input logic r);
    stall = s; skip_mask = sk; halt_req = h; resume = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " phase"}, 32'(phase), 32'd1);
    chk({nm, " idx"}, 32'(phase_idx), 32'd0);
    chk({nm, " done"}, 32'(instr_done), 32'd0);
    chk({nm, " halted"}, 32'(halted), 32'd0);
    chk({nm, " cyc"}, cyc_cnt, 32'd0);
    chk({nm, " ins"}, ins_cnt, 32'd0);
  endtask

  // Reference model state, kept as plain integers and a bit array.
  bit          m_halted;
  int          m_idx;
  bit          m_mask[N];
  bit          m_pend;
  bit          m_done;
  int unsigned m_cyc, m_ins;

  task automatic model_reset();
    m_halted = 0; m_idx = 0; m_pend = 0; m_done = 0; m_cyc = 0; m_ins = 0;
    for (int i = 0; i < N; i++) m_mask[i] = 0;
  endtask

  task automatic model_step(input bit s, input logic [N-1:0] sk, input bit h, input bit r);
    int nx;
    m_done = 0;
    if (!m_halted) begin
      m_cyc++;
      if (s) m_pend = m_pend | h;
      else begin
        if (m_idx == 0) for (int i = 0; i < N; i++) m_mask[i] = (i == 0) ? 1'b0 : sk[i];
        nx = -1;
        for (int j = N - 1; j > m_idx; j--) if (!m_mask[j]) nx = j;
        if (nx < 0) begin
          m_done = 1; m_ins++; m_idx = 0;
          if (m_pend || h) begin m_halted = 1; m_pend = 0; end
        end else begin
          m_idx = nx; m_pend = m_pend | h;
        end
      end
    end else if (r) begin
      m_halted = 0; m_idx = 0; m_pend = h;
    end
  endtask

  initial begin
    logic [N-1:0] p0;
    p0 = '0;
    rst = 1'b1;
    drive(0, '0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // Plain 5-phase run.
    for (int c = 0; c < 3; c++) begin
      t(0,0,0,0, 5'd2,0,0); t(0,0,0,0, 5'd4,0,0); t(0,0,0,0, 5'd8,0,0);
      t(0,0,0,0, 5'd16,0,0); t(0,0,0,0, 5'd1,1,0);
    end
    // Skip MEM.
    t(0,5'b01000,0,0, 5'd2,0,0); t(0,0,0,0, 5'd4,0,0); t(0,0,0,0, 5'd16,0,0); t(0,0,0,0, 5'd1,1,0);
    // Everything skipped: fetch-only instructions.
    t(0,5'b11110,0,0, 5'd1,1,0); t(0,5'b11111,0,0, 5'd1,1,0); t(0,5'b11110,0,0, 5'd1,1,0);
    t(0,0,0,0, 5'd2,0,0); t(0,0,0,0, 5'd4,0,0); t(0,0,0,0, 5'd8,0,0);
    // Stall at phase 8.
    t(1,0,0,0, 5'd8,0,0); t(1,0,0,0, 5'd8,0,0); t(1,0,0,0, 5'd8,0,0);
    t(0,0,0,0, 5'd16,0,0); t(0,0,0,0, 5'd1,1,0);
    // Halt request mid-instruction, then resume four cycles later.
    t(0,0,0,0, 5'd2,0,0); t(0,0,1,0, 5'd4,0,0); t(0,0,0,0, 5'd8,0,0); t(0,0,0,0, 5'd16,0,0);
    t(0,0,0,0, 5'd0,1,1); t(1,5'b11110,0,0, 5'd0,0,1); t(0,0,0,0, 5'd0,0,1); t(0,0,0,0, 5'd0,0,1);
    t(0,0,0,1, 5'd1,0,0); t(0,0,0,0, 5'd2,0,0); t(0,0,0,0, 5'd4,0,0); t(0,0,0,0, 5'd8,0,0);
    // Halt latched during a stall at the boundary; stall wins.
    t(0,0,0,0, 5'd16,0,0); t(1,0,1,0, 5'd16,0,0); t(0,0,0,0, 5'd0,1,1);
    // Resume together with halt: one instruction, then halted again.
    t(0,0,1,1, 5'd1,0,0); t(0,0,0,0, 5'd2,0,0); t(0,0,0,0, 5'd4,0,0); t(0,0,0,0, 5'd8,0,0);
    t(0,0,0,0, 5'd16,0,0); t(0,0,0,0, 5'd0,1,1); t(0,0,0,1, 5'd1,0,0);
    // Stall in fetch does not latch the mask; then halt_req exactly at the boundary.
    t(1,5'b11110,0,0, 5'd1,0,0); t(0,0,0,0, 5'd2,0,0); t(0,0,0,0, 5'd4,0,0); t(0,0,0,0, 5'd8,0,0);
    t(0,0,0,0, 5'd16,0,0); t(0,0,1,0, 5'd0,1,1); t(0,0,0,1, 5'd1,0,0);

    foreach (tv[i]) begin
      drive(tv[i].stall, tv[i].skip, tv[i].halt, tv[i].res);
      tick();
      chk($sformatf("vec%0d phase", i), 32'(phase), 32'(tv[i].exp_phase));
      chk($sformatf("vec%0d idx", i), 32'(phase_idx), 32'(idx_of(tv[i].exp_phase)));
      chk($sformatf("vec%0d done", i), 32'(instr_done), 32'(tv[i].exp_done));
      chk($sformatf("vec%0d halted", i), 32'(halted), 32'(tv[i].exp_halted));
    end

    // Counters: two instructions plus two stall cycles from reset.
    rst = 1'b1; drive(0, '0, 0, 0); tick(); rst = 1'b0;
    chk_reset("reset2");
    for (int c = 0; c < 12; c++) begin
      drive((c == 2 || c == 3), '0, 0, 0);
      tick();
    end
    chk("perf phase", 32'(phase), 32'd1);
    chk("perf done", 32'(instr_done), 32'd1);
`ifdef PHASE_SEQ_PERF_CNT_EN
    chk("perf cyc", cyc_cnt, 32'd12);
    chk("perf ins", ins_cnt, 32'd2);
`else
    chk("perf cyc", cyc_cnt, 32'd0);
    chk("perf ins", ins_cnt, 32'd0);
`endif
    // Reset in the middle of phase 4.
    drive(0, '0, 1, 0); tick(); tick();
    chk("pre-rst phase", 32'(phase), 32'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst mid");
    drive(0, '0, 0, 0); tick();
    chk("post-rst phase", 32'(phase), 32'd2);
    // Reset while halted (pending halt from before reset must be gone).
    tick(); tick(); tick(); drive(0, '0, 1, 0); tick();
    chk("halt before rst", 32'(halted), 32'd1);
    drive(0, '0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst halted");

    // Randomized run against the model.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic s, h, r;
      logic [N-1:0] sk;
      s  = ($urandom_range(0, 3) == 0);
      sk = N'($urandom);
      h  = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
      drive(s, sk, h, r);
      @(posedge clk);
      if (rst) model_reset();
      else model_step(s, sk, h, r);
      #1;
      p0 = m_halted ? '0 : N'(1 << m_idx);
      chk($sformatf("rnd%0d phase", c), 32'(phase), 32'(p0));
      chk($sformatf("rnd%0d idx", c), 32'(phase_idx), 32'(m_idx));
      chk($sformatf("rnd%0d done", c), 32'(instr_done), 32'(m_done));
      chk($sformatf("rnd%0d halted", c), 32'(halted), 32'(m_halted));
`ifdef PHASE_SEQ_PERF_CNT_EN
      chk($sformatf("rnd%0d cyc", c), cyc_cnt, m_cyc);
      chk($sformatf("rnd%0d ins", c), ins_cnt, m_ins);
`endif
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
